// File: rtl/lpc_cycle_serializer_if.sv
// rtl/lpc_cycle_serializer_if.sv - decoded-cycle input, frame byte stream and capture-loss status bundle
interface lpc_cycle_serializer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  in_valid;
    logic                  in_mode;
    logic                  in_direction;
    logic [15:0]           in_addr;
    logic [7:0]            in_data;
    logic [7:0]            out_byte;
    logic                  out_valid;
    logic                  out_ready;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic                  overflow;
    logic [7:0]            drop_count;
    logic                  clear_stats;

    modport master (
        output in_valid, in_mode, in_direction, in_addr, in_data,
        output out_ready, clear_stats,
        input  out_byte, out_valid, fifo_level, overflow, drop_count
    );

    modport slave (
        input  in_valid, in_mode, in_direction, in_addr, in_data,
        input  out_ready, clear_stats,
        output out_byte, out_valid, fifo_level, overflow, drop_count
    );
endinterface

// File: rtl/lpc_cycle_serializer.sv
// rtl/lpc_cycle_serializer.sv - buffers decoded LPC cycles and emits each as a 4-byte frame
module lpc_cycle_serializer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   lpc_clk,
    input  logic                   lpc_reset,
    lpc_cycle_serializer_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_B3
    } state_t;

    logic [25:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_loss;
    logic                  r_overflow;
    logic [7:0]            r_drop_count;
    // {loss, mode, direction, addr, data} of the frame in flight
    logic [26:0]           r_hold;
    state_t                r_state;
    logic [7:0]            r_out_byte;
    logic                  r_out_valid;

    state_t                w_next_state;
    logic [7:0]            w_next_byte;
    logic                  w_next_valid;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic [25:0]           w_in_entry;
    logic [25:0]           w_head;

    assign w_full     = (r_level == LEVEL_FULL);
    assign w_push     = bus.in_valid & ~w_full;
    assign w_drop     = bus.in_valid & w_full;
    assign w_in_entry = {bus.in_mode, bus.in_direction, bus.in_addr, bus.in_data};
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge lpc_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge lpc_clk or posedge lpc_reset) begin
        if (lpc_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop in the pop cycle belongs to a later record, so it re-arms the loss flag.
    always_ff @(posedge lpc_clk or posedge lpc_reset) begin
        if (lpc_reset) begin
            r_loss       <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else begin
            if (w_drop) begin
                r_loss <= 1'b1;
            end else if (w_pop) begin
                r_loss <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (bus.clear_stats) begin
                    r_drop_count <= 8'h01;
                end else if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'h01;
                end
            end else if (bus.clear_stats) begin
                r_overflow   <= 1'b0;
                r_drop_count <= 8'h00;
            end
        end
    end

    always_ff @(posedge lpc_clk or posedge lpc_reset) begin
        if (lpc_reset) begin
            r_hold      <= '0;
            r_state     <= ST_IDLE;
            r_out_byte  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_hold <= {r_loss, w_head};
            end
            r_state     <= w_next_state;
            r_out_byte  <= w_next_byte;
            r_out_valid <= w_next_valid;
        end
    end

    // B0 spends one cycle loading its byte, so the first byte appears two edges after the push.
    always_comb begin
        w_next_state = r_state;
        w_next_byte  = r_out_byte;
        w_next_valid = r_out_valid;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_valid = 1'b0;
                if (r_level != '0) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_B0;
                end
            end
            ST_B0: begin
                if (!r_out_valid) begin
                    w_next_valid = 1'b1;
                    w_next_byte  = {4'b1010, 1'b0, r_hold[26], r_hold[25], r_hold[24]};
                end else if (bus.out_ready) begin
                    w_next_state = ST_B1;
                    w_next_byte  = r_hold[23:16];
                end
            end
            ST_B1: begin
                if (bus.out_ready) begin
                    w_next_state = ST_B2;
                    w_next_byte  = r_hold[15:8];
                end
            end
            ST_B2: begin
                if (bus.out_ready) begin
                    w_next_state = ST_B3;
                    w_next_byte  = r_hold[7:0];
                end
            end
            ST_B3: begin
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                    w_next_valid = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_valid = 1'b0;
            end
        endcase
    end

    assign bus.out_byte   = r_out_byte;
    assign bus.out_valid  = r_out_valid;
    assign bus.fifo_level = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_lpc_cycle_serializer.sv
// tb/tb_lpc_cycle_serializer.sv - directed bench for lpc_cycle_serializer
module tb_lpc_cycle_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    lpc_cycle_serializer_if #(.DEPTH_LOG2(4)) bus ();

    lpc_cycle_serializer #(.DEPTH_LOG2(4)) dut (
        .lpc_clk   (clk),
        .lpc_reset (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rec(input logic m, input logic d, input logic [15:0] a, input logic [7:0] dt);
        bus.in_valid     = 1'b1;
        bus.in_mode      = m;
        bus.in_direction = d;
        bus.in_addr      = a;
        bus.in_data      = dt;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
        int         n;
        logic [7:0] exp_b [4];
        exp_b = '{b0, b1, b2, b3};
        n = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_b%0d", tag, k), {bus.out_valid, bus.out_byte}, {1'b1, exp_b[k]});
            tick();
        end
        check({tag, "_end"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        int         pushed;
        int         got;
        int         cyc;
        int         max_lvl;
        int         extra;
        logic [7:0] exp_q [$];
        logic       m;
        logic       d;
        logic [15:0] a;
        logic [7:0] dt;

        bus.in_valid     = 1'b0;
        bus.in_mode      = 1'b0;
        bus.in_direction = 1'b0;
        bus.in_addr      = 16'h0000;
        bus.in_data      = 8'h00;
        bus.out_ready    = 1'b0;
        bus.clear_stats  = 1'b0;
        repeat (3) tick();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_byte", bus.out_byte, 8'h00);
        check("rst_level", bus.fifo_level, 5'd0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_drops", bus.drop_count, 8'h00);
        rst = 1'b0;
        tick();

        // single record, sink always ready
        bus.out_ready = 1'b1;
        drive_rec(1'b1, 1'b1, 16'h0080, 8'h5A);
        tick();
        bus.in_valid = 1'b0;
        check("t1_level_push", bus.fifo_level, 5'd1);
        check("t1_valid_push", bus.out_valid, 1'b0);
        tick();
        check("t1_level_pop", bus.fifo_level, 5'd0);
        check("t1_valid_pop", bus.out_valid, 1'b0);
        tick();
        check("t1_b0", {bus.out_valid, bus.out_byte}, 9'h1A3);
        tick();
        check("t1_b1", {bus.out_valid, bus.out_byte}, 9'h100);
        tick();
        check("t1_b2", {bus.out_valid, bus.out_byte}, 9'h180);
        tick();
        check("t1_b3", {bus.out_valid, bus.out_byte}, 9'h15A);
        tick();
        check("t1_end", bus.out_valid, 1'b0);

        // backpressure while B1 is presented
        drive_rec(1'b1, 1'b1, 16'h0080, 8'h5A);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("t2_b0", {bus.out_valid, bus.out_byte}, 9'h1A3);
        tick();
        check("t2_b1", {bus.out_valid, bus.out_byte}, 9'h100);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t2_hold%0d", k), {bus.out_valid, bus.out_byte}, 9'h100);
        end
        bus.out_ready = 1'b1;
        tick();
        check("t2_b2", {bus.out_valid, bus.out_byte}, 9'h180);
        tick();
        check("t2_b3", {bus.out_valid, bus.out_byte}, 9'h15A);
        tick();
        check("t2_end", bus.out_valid, 1'b0);

        // 20 pushes into a stalled sink: record 0 is popped, 16 stored, 3 dropped
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_rec(1'b0, 1'b1, 16'h1200 + 16'(i), 8'(i));
            tick();
        end
        bus.in_valid = 1'b0;
        check("t3_level", bus.fifo_level, 5'd16);
        check("t3_overflow", bus.overflow, 1'b1);
        check("t3_drops", bus.drop_count, 8'd3);
        check("t3_stalled_b0", {bus.out_valid, bus.out_byte}, 9'h1A1);
        expect_frame("t3_f0", 8'hA1, 8'h12, 8'h00, 8'h00);
        expect_frame("t3_f1", 8'hA5, 8'h12, 8'h01, 8'h01);
        expect_frame("t3_f2", 8'hA1, 8'h12, 8'h02, 8'h02);
        for (int k = 3; k < 17; k++) begin
            expect_frame($sformatf("t3_f%0d", k), 8'hA1, 8'h12, 8'(k), 8'(k));
        end
        check("t3_level_drained", bus.fifo_level, 5'd0);
        check("t3_drops_kept", bus.drop_count, 8'd3);

        // saturation: 17 accepted then 300 dropped
        bus.out_ready = 1'b0;
        for (int i = 0; i < 317; i++) begin
            drive_rec(1'b0, 1'b0, 16'h0000, 8'h00);
            tick();
        end
        bus.in_valid = 1'b0;
        check("t4_level", bus.fifo_level, 5'd16);
        check("t4_drops_sat", bus.drop_count, 8'hFF);
        check("t4_overflow", bus.overflow, 1'b1);
        bus.clear_stats = 1'b1;
        tick();
        bus.clear_stats = 1'b0;
        check("t4_clr_overflow", bus.overflow, 1'b0);
        check("t4_clr_drops", bus.drop_count, 8'h00);
        bus.clear_stats = 1'b1;
        drive_rec(1'b0, 1'b0, 16'h0000, 8'h00);
        tick();
        bus.clear_stats = 1'b0;
        bus.in_valid    = 1'b0;
        check("t4_clr_drop_overflow", bus.overflow, 1'b1);
        check("t4_clr_drop_count", bus.drop_count, 8'h01);

        // asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        check("t4_arst_valid", bus.out_valid, 1'b0);
        check("t4_arst_byte", bus.out_byte, 8'h00);
        check("t4_arst_level", bus.fifo_level, 5'd0);
        check("t4_arst_overflow", bus.overflow, 1'b0);
        check("t4_arst_drops", bus.drop_count, 8'h00);
        tick();
        rst = 1'b0;
        tick();

        // pointer wrap: 40 records, random sink stalls, scoreboard of expected bytes
        pushed  = 0;
        got     = 0;
        cyc     = 0;
        max_lvl = 0;
        while ((pushed < 40 || exp_q.size() != 0) && cyc < 4000) begin
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid === 1'b1 && bus.out_ready && exp_q.size() != 0) begin
                check($sformatf("t5_byte%0d", got), bus.out_byte, exp_q.pop_front());
                got++;
            end
            bus.in_valid = 1'b0;
            if (pushed < 40 && bus.fifo_level < 5'd16 && $urandom_range(0, 2) != 0) begin
                m  = 1'($urandom_range(0, 1));
                d  = 1'($urandom_range(0, 1));
                a  = 16'($urandom);
                dt = 8'($urandom);
                drive_rec(m, d, a, dt);
                exp_q.push_back({4'b1010, 1'b0, 1'b0, m, d});
                exp_q.push_back(a[15:8]);
                exp_q.push_back(a[7:0]);
                exp_q.push_back(dt);
                pushed++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("t5_bytes_total", got, 160);
        check("t5_max_level_le16", max_lvl <= 16, 1'b1);
        bus.out_ready = 1'b1;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid === 1'b1) extra++;
            tick();
        end
        check("t5_no_extra_bytes", extra, 0);

        // reset while B2 is presented, with one more record queued behind it
        bus.out_ready = 1'b0;
        drive_rec(1'b1, 1'b0, 16'hBEEF, 8'h77);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("t6_b0", {bus.out_valid, bus.out_byte}, 9'h1A2);
        bus.out_ready = 1'b1;
        drive_rec(1'b0, 1'b1, 16'h4444, 8'h44);
        tick();
        bus.in_valid = 1'b0;
        check("t6_b1", {bus.out_valid, bus.out_byte}, 9'h1BE);
        tick();
        check("t6_b2", {bus.out_valid, bus.out_byte}, 9'h1EF);
        bus.out_ready = 1'b0;
        check("t6_level_before", bus.fifo_level, 5'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_arst_valid", bus.out_valid, 1'b0);
        check("t6_arst_level", bus.fifo_level, 5'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_quiet%0d", k), bus.out_valid, 1'b0);
        end
        drive_rec(1'b0, 1'b0, 16'h0102, 8'h03);
        tick();
        bus.in_valid = 1'b0;
        expect_frame("t6_post", 8'hA0, 8'h01, 8'h02, 8'h03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
